// File: rtl/spram_pkg.sv
// Shared types and default geometry for the single-port RAM and its request controller.
package spram_pkg;

   typedef enum logic [1:0] {StInit, StRun, StDrain} state_e;

   localparam int unsigned DefDwidth   = 8;
   localparam int unsigned DefAwidth   = 8;
   localparam int unsigned DefMemdepth = 256;

endpackage

// File: rtl/spram_rsp_fifo.sv
// Response FIFO holding captured RAM read data until the consumer takes it.
// Head data reads as zero while empty so the output is well defined.
module spram_rsp_fifo #(
   parameter int unsigned DWIDTH    = 8,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic [DWIDTH-1:0]                push_data,
   input  logic                             pop,
   output logic [$clog2(RSP_DEPTH + 1)-1:0] count,
   output logic                             empty,
   output logic [DWIDTH-1:0]                head_data
);

   localparam int unsigned CntW     = $clog2(RSP_DEPTH + 1);
   localparam int unsigned PtrW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned LastSlot = RSP_DEPTH - 1;
   localparam logic [PtrW-1:0] LastPtr = LastSlot[PtrW-1:0];

   logic [DWIDTH-1:0] mem_q [RSP_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              do_push, do_pop;

   // The upstream credit rule guarantees push never arrives while full.
   assign do_push   = push;
   assign do_pop    = pop && (count_q != '0);
   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign head_data = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/spram_req_ctrl.sv
// Request-side controller for the single-port RAM: zero-fill on reset/clear, then
// one access per cycle with read data queued in order behind a credit-limited FIFO.
module spram_req_ctrl
   import spram_pkg::*;
#(
   parameter int unsigned DWIDTH    = DefDwidth,
   parameter int unsigned AWIDTH    = DefAwidth,
   parameter int unsigned MEMDEPTH  = DefMemdepth,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              ram_en,
   output logic              ram_wen,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_datai,
   input  logic [DWIDTH-1:0] ram_datao
);

   localparam int unsigned CntW    = $clog2(RSP_DEPTH + 1);
   localparam int unsigned LastIdx = MEMDEPTH - 1;
   localparam logic [AWIDTH-1:0] LastAddr  = LastIdx[AWIDTH-1:0];
   localparam logic [CntW:0]     CreditMax = RSP_DEPTH[CntW:0];

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic [CntW-1:0]   fifo_count;
   logic              fifo_empty;
   logic [CntW:0]     credit_used;
   logic              accept;

   // Reads in flight plus queued responses may never exceed the FIFO size.
   assign credit_used = {1'b0, fifo_count} + {{CntW{1'b0}}, rd_pend_q};
   assign req_ready   = (state_q == StRun) && (credit_used < CreditMax);
   assign accept      = req_valid && req_ready;
   assign busy        = (state_q != StRun);
   assign rsp_valid   = !fifo_empty;

   always_comb begin
      ram_en    = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = req_addr;
      ram_datai = req_wdata;
      if (state_q == StInit) begin
         ram_en    = 1'b1;
         ram_wen   = 1'b1;
         ram_addr  = cnt_q;
         ram_datai = '0;
      end else if (accept) begin
         ram_en  = 1'b1;
         ram_wen = req_wr;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_pend_d = accept && !req_wr;
      unique case (state_q)
         StInit: begin
            cnt_d = cnt_q + AWIDTH'(1);
            if (cnt_q == LastAddr) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            if (clr_req) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // A pending read is captured this cycle, so INIT may follow right away.
            if (!rd_pend_d) begin
               state_d = StInit;
               cnt_d   = '0;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StInit;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   spram_rsp_fifo #(
      .DWIDTH    (DWIDTH),
      .RSP_DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_pend_q),
      .push_data (ram_datao),
      .pop       (rsp_ready),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .head_data (rsp_rdata)
   );

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Self-checking bench for spram_req_ctrl: behavioural RAM, reference memory and
// an in-order expected-response queue.
module tb_spram_req_ctrl;

   localparam int unsigned RD = 4;
   localparam int unsigned MD = 256;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr_req = 1'b0;
   logic       busy;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_wr = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_rdata;
   logic       ram_en;
   logic       ram_wen;
   logic [7:0] ram_addr;
   logic [7:0] ram_datai;
   logic [7:0] ram_datao = 8'h00;

   always #5 clk = ~clk;

   spram_req_ctrl #(
      .DWIDTH    (8),
      .AWIDTH    (8),
      .MEMDEPTH  (MD),
      .RSP_DEPTH (RD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr_req   (clr_req),
      .busy      (busy),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram_en    (ram_en),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_datai (ram_datai),
      .ram_datao (ram_datao)
   );

   // Single-port RAM: write-first storage, read data for one cycle, zero otherwise.
   logic [7:0] ram_mem [256];
   always @(posedge clk) begin
      if (ram_en && ram_wen) ram_mem[ram_addr] <= ram_datai;
      ram_datao <= (ram_en && !ram_wen) ? ram_mem[ram_addr] : 8'h00;
   end

   logic [7:0] ref_mem [256];
   logic [7:0] exp_q [$];
   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc = 0;

   logic       obs_acc, obs_pop, obs_rv, obs_rdy, obs_busy, obs_en, obs_wen;
   logic [7:0] obs_rd, obs_addr;
   int         obs_pre;

   // One clock cycle of stimulus; records what the DUT showed and updates the model.
   task automatic drive_cycle(input logic v, input logic wr, input logic [7:0] a,
                              input logic [7:0] d, input logic rr, input logic clr);
      @(negedge clk);
      req_valid = v;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      rsp_ready = rr;
      clr_req   = clr;
      #1;
      cyc++;
      obs_pre  = exp_q.size();
      obs_rdy  = req_ready;
      obs_acc  = v && req_ready;
      obs_rv   = rsp_valid;
      obs_pop  = rsp_valid && rr;
      obs_rd   = rsp_rdata;
      obs_busy = busy;
      obs_en   = ram_en;
      obs_wen  = ram_wen;
      obs_addr = ram_addr;
      if (obs_acc) begin
         if (wr) ref_mem[a] = d;
         else exp_q.push_back(ref_mem[a]);
      end
   endtask

   task automatic test_init_sweep(input string tag);
      @(negedge clk);
      req_valid = 1'b0;
      clr_req   = 1'b0;
      rst       = 1'b0;
      #1;
      for (int i = 0; i < MD; i++) begin
         if (i != 0) begin
            @(negedge clk);
            #1;
         end
         n_cmp++;
         if (ram_en !== 1'b1 || ram_wen !== 1'b1 || ram_addr !== 8'(i) ||
             ram_datai !== 8'h00 || busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_init[%0d]: en=%b wen=%b addr=%h datai=%h busy=%b ready=%b, required 1 1 %h 00 1 0",
                     tag, i, ram_en, ram_wen, ram_addr, ram_datai, busy, req_ready, 8'(i));
         end
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_run_entry: busy=%b ready=%b, required 0 1", tag, busy, req_ready);
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b ready=%b rsp_valid=%b rsp_rdata=%h, required 1 0 0 00",
                  busy, req_ready, rsp_valid, rsp_rdata);
      end
      test_init_sweep("reset");
   endtask

   task automatic test_raw();
      int         t_acc;
      int         got;
      logic [7:0] exp;
      drive_cycle(1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 1'b0);
      n_cmp++;
      if (obs_acc !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_write_accept: got %b, required 1", obs_acc);
      end
      for (int j = 0; j < 2; j++) begin
         drive_cycle(1'b1, 1'b0, (j == 0) ? 8'h10 : 8'h20, 8'h00, 1'b1, 1'b0);
         t_acc = cyc;
         n_cmp++;
         if (obs_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_read_accept[%0d]: got %b, required 1", j, obs_acc);
         end
         got = 0;
         for (int k = 0; k < 6 && got == 0; k++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            if (obs_pop) begin
               got = 1;
               exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
               n_cmp++;
               if (cyc - t_acc != 2) begin
                  n_fail++;
                  $display("FAIL raw_latency[%0d]: got %0d cycles, required 2", j, cyc - t_acc);
               end
               n_cmp++;
               if (obs_rd !== exp) begin
                  n_fail++;
                  $display("FAIL raw_data[%0d]: got %h, required %h", j, obs_rd, exp);
               end
            end
         end
         if (got == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL raw_timeout[%0d]: no response, required one within 6 cycles", j);
         end
      end
   endtask

   task automatic test_back_to_back();
      int         nrsp;
      int         first;
      int         last;
      logic [7:0] exp;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, 1'b1, 8'(i), 8'(8'h30 + i), 1'b1, 1'b0);
         n_cmp++;
         if (obs_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_preload[%0d]: accept=%b, required 1", i, obs_acc);
         end
      end
      nrsp  = 0;
      first = 0;
      last  = 0;
      for (int k = 0; k < 20 && nrsp < 8; k++) begin
         if (k < 8) drive_cycle(1'b1, 1'b0, 8'(k), 8'h00, 1'b1, 1'b0);
         else drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
         if (k < 8) begin
            n_cmp++;
            if (obs_acc !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_ready[%0d]: accept=%b, required 1", k, obs_acc);
            end
         end
         if (obs_pop) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            if (nrsp == 0) first = cyc;
            last = cyc;
            nrsp++;
            n_cmp++;
            if (obs_rd !== exp) begin
               n_fail++;
               $display("FAIL b2b_data[%0d]: got %h, required %h", nrsp - 1, obs_rd, exp);
            end
         end
      end
      n_cmp++;
      if (nrsp != 8 || last - first != 7) begin
         n_fail++;
         $display("FAIL b2b_stream: %0d responses over %0d cycles, required 8 over 7",
                  nrsp, last - first);
      end
   endtask

   task automatic test_backpressure();
      int         nacc;
      int         nrsp;
      logic [7:0] exp;
      nacc = 0;
      for (int k = 0; k < 8; k++) begin
         drive_cycle(1'b1, 1'b0, 8'($urandom_range(0, 7)), 8'h00, 1'b0, 1'b0);
         if (obs_acc) nacc++;
      end
      n_cmp++;
      if (nacc != RD) begin
         n_fail++;
         $display("FAIL bp_accepts: got %0d, required %0d", nacc, RD);
      end
      drive_cycle(1'b1, 1'b1, 8'h40, 8'h99, 1'b0, 1'b0);
      n_cmp++;
      if (obs_acc !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_write_blocked: accept=%b, required 0", obs_acc);
      end
      nrsp = 0;
      for (int k = 0; k < 12 && nrsp < 4; k++) begin
         drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
         if (obs_pop) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            nrsp++;
            n_cmp++;
            if (obs_rd !== exp) begin
               n_fail++;
               $display("FAIL bp_data[%0d]: got %h, required %h", nrsp - 1, obs_rd, exp);
            end
         end
      end
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (nrsp != 4 || obs_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_recover: %0d responses ready=%b, required 4 and 1", nrsp, obs_rdy);
      end
   endtask

   task automatic test_clear();
      int         nbusy;
      int         got;
      int         done;
      logic [7:0] exp;
      drive_cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1);
      n_cmp++;
      if (obs_acc !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_read_accept: got %b, required 1", obs_acc);
      end
      nbusy = 0;
      got   = 0;
      done  = 0;
      for (int k = 0; k < 400 && done == 0; k++) begin
         drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
         if (obs_pop) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            got++;
            n_cmp++;
            if (obs_rd !== exp) begin
               n_fail++;
               $display("FAIL clr_inflight_data: got %h, required %h", obs_rd, exp);
            end
         end
         if (obs_busy) nbusy++;
         else done = 1;
      end
      n_cmp++;
      if (got != 1 || nbusy != 1 + MD || done == 0) begin
         n_fail++;
         $display("FAIL clr_busy: %0d responses, busy %0d cycles, required 1 and %0d",
                  got, nbusy, 1 + MD);
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      drive_cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0);
      got = 0;
      for (int k = 0; k < 6 && got == 0; k++) begin
         drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
         if (obs_pop) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            got = 1;
            n_cmp++;
            if (obs_rd !== exp) begin
               n_fail++;
               $display("FAIL clr_zeroed: got %h, required %h", obs_rd, exp);
            end
         end
      end
      if (got == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL clr_zeroed_timeout: no response, required one");
      end
   endtask

   task automatic test_random();
      logic       v, wr, rr;
      logic [7:0] exp;
      for (int k = 0; k < 420; k++) begin
         v  = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         rr = (k >= 400) || ($urandom_range(0, 3) != 0);
         if (k >= 400) v = 1'b0;
         drive_cycle(v, wr, 8'($urandom_range(0, 15)), 8'($urandom), rr, 1'b0);
         n_cmp++;
         if (obs_rdy !== (obs_pre < RD) || obs_pre > RD) begin
            n_fail++;
            $display("FAIL rand_credit[%0d]: ready=%b outstanding=%0d, required ready=%b limit %0d",
                     k, obs_rdy, obs_pre, obs_pre < RD, RD);
         end
         if (obs_pop) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            n_cmp++;
            if (obs_rd !== exp) begin
               n_fail++;
               $display("FAIL rand_data[%0d]: got %h, required %h", k, obs_rd, exp);
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_drain: %0d responses missing, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid_init();
      int found;
      drive_cycle(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      found = 0;
      for (int k = 0; k < 400 && found == 0; k++) begin
         drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
         if (obs_busy && obs_en && obs_wen && obs_addr == 8'h80) found = 1;
      end
      n_cmp++;
      if (found == 0 || obs_rv !== 1'b1 || exp_q.size() != 2) begin
         n_fail++;
         $display("FAIL mid_setup: reached 0x80=%0d rsp_valid=%b queued=%0d, required 1 1 2",
                  found, obs_rv, exp_q.size());
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1 || rsp_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: rsp_valid=%b busy=%b rsp_rdata=%h, required 0 1 00",
                  rsp_valid, busy, rsp_rdata);
      end
      test_init_sweep("mid");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_raw();
      test_back_to_back();
      test_backpressure();
      test_clear();
      test_random();
      test_reset_mid_init();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
